// File: rtl/lstm_pkg.sv
// Shared types for the LSTM time-series sequencer: default widths, data word, FSM states.
package lstm_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  typedef logic signed [WIDTH-1:0] lstm_word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } lstm_seq_state_e;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// Sample stream, cell operand/result and hidden-state stream around lstm_seq_ctrl.
// master = sequencer view, slave = surrounding source/cell/sink view.
interface lstm_seq_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);

  logic signed [WIDTH-1:0] s_x;
  logic                    s_last;
  logic                    s_valid;
  logic                    s_ready;

  logic signed [WIDTH-1:0] cell_x_in;
  logic signed [WIDTH-1:0] cell_h_in;
  logic signed [WIDTH-1:0] cell_C_in;
  logic                    cell_x_valid;
  logic                    cell_x_ready;
  logic signed [WIDTH-1:0] cell_y_out;
  logic signed [WIDTH-1:0] cell_C_out;
  logic                    cell_y_valid;

  logic signed [WIDTH-1:0] m_h;
  logic [CNT_W-1:0]        m_step;
  logic                    m_last;
  logic                    m_valid;
  logic                    m_ready;

  logic                    err_unexpected;

  modport master (
    input  s_x, s_last, s_valid, cell_x_ready, cell_y_out, cell_C_out, cell_y_valid, m_ready,
    output s_ready, cell_x_in, cell_h_in, cell_C_in, cell_x_valid,
           m_h, m_step, m_last, m_valid, err_unexpected
  );

  modport slave (
    output s_x, s_last, s_valid, cell_x_ready, cell_y_out, cell_C_out, cell_y_valid, m_ready,
    input  s_ready, cell_x_in, cell_h_in, cell_C_in, cell_x_valid,
           m_h, m_step, m_last, m_valid, err_unexpected
  );

endinterface

// File: rtl/lstm_seq_ctrl.sv
// Steps a single-step lstm cell across a sample stream, holding h/C between steps.
// Define LSTM_SEQ_FINAL_ONLY_EN to emit only the final step of each sequence.
module lstm_seq_ctrl #(
  parameter int WIDTH = lstm_pkg::WIDTH,
  parameter int CNT_W = lstm_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst,
  lstm_seq_ctrl_if.master bus
);

  import lstm_pkg::*;

  localparam logic [CNT_W-1:0] STEP_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1'b1);

  lstm_seq_state_e         r_state;
  lstm_seq_state_e         w_state_nxt;
  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_h;
  logic signed [WIDTH-1:0] r_c;
  logic [CNT_W-1:0]        r_step;
  logic                    r_last;
  logic                    r_s_ready;
  logic                    r_cell_x_valid;
  logic                    r_m_valid;
  logic                    r_err;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_out_hs;
  logic                    w_skip;

  // Next-state decode; handshakes are qualified by the registered valid/ready we present.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_out_hs    = 1'b0;
    w_skip      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.s_valid && r_s_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (bus.cell_x_ready && r_cell_x_valid) begin
          w_state_nxt = WAIT;
        end else begin
          w_state_nxt = ISSUE;
        end
      end
      WAIT: begin
        if (bus.cell_y_valid) begin
          w_capture = 1'b1;
`ifdef LSTM_SEQ_FINAL_ONLY_EN
          if (r_last) begin
            w_state_nxt = OUT;
          end else begin
            w_state_nxt = IDLE;
            w_skip      = 1'b1;
          end
`else
          w_state_nxt = OUT;
`endif
        end else begin
          w_state_nxt = WAIT;
        end
      end
      OUT: begin
        if (bus.m_ready && r_m_valid) begin
          w_out_hs    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s_ready      <= 1'b0;
      r_cell_x_valid <= 1'b0;
      r_m_valid      <= 1'b0;
    end else begin
      r_s_ready      <= (w_state_nxt == IDLE);
      r_cell_x_valid <= (w_state_nxt == ISSUE);
      r_m_valid      <= (w_state_nxt == OUT);
    end
  end

  // Sample, recurrent state and step counter; a last step returns h/C/step to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x    <= '0;
      r_last <= 1'b0;
      r_h    <= '0;
      r_c    <= '0;
      r_step <= '0;
    end else begin
      if (w_accept) begin
        r_x    <= bus.s_x;
        r_last <= bus.s_last;
      end
      if (w_out_hs && r_last) begin
        r_h    <= '0;
        r_c    <= '0;
        r_step <= '0;
      end else begin
        if (w_capture) begin
          r_h <= bus.cell_y_out;
          r_c <= bus.cell_C_out;
        end
        if ((w_out_hs || w_skip) && (r_step != STEP_MAX)) begin
          r_step <= r_step + STEP_ONE;
        end
      end
    end
  end

  // Sticky flag for a cell result arriving when no step is outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (bus.cell_y_valid && (r_state != WAIT)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.s_ready        = r_s_ready;
  assign bus.cell_x_valid   = r_cell_x_valid;
  assign bus.cell_x_in      = r_x;
  assign bus.cell_h_in      = r_h;
  assign bus.cell_C_in      = r_c;
  assign bus.m_h            = r_h;
  assign bus.m_step         = r_step;
  assign bus.m_last         = r_last;
  assign bus.m_valid        = r_m_valid;
  assign bus.err_unexpected = r_err;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Directed bench for lstm_seq_ctrl with a latency-3 stub cell (y = x + h, C_out = C + 1).
module tb_lstm_seq_ctrl;
  import lstm_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  lstm_seq_ctrl_if #(.WIDTH(W), .CNT_W(16)) bus ();
  lstm_seq_ctrl_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

  lstm_seq_ctrl #(.WIDTH(W), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  lstm_seq_ctrl #(.WIDTH(W), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // stub cells: not reset by rst, so an in-flight result still returns after a DUT reset
  logic [2:0] st_v = 3'b000;
  lstm_word_t st_y [3];
  lstm_word_t st_c [3];
  int         n_hs = 0;
  logic [2:0] st2_v = 3'b000;
  lstm_word_t st2_y [3];
  lstm_word_t st2_c [3];

  always @(posedge clk) begin
    st_v  <= {st_v[1:0], bus.cell_x_valid & bus.cell_x_ready};
    st_y[0] <= bus.cell_x_in + bus.cell_h_in;
    st_c[0] <= bus.cell_C_in + 16'sd1;
    st_y[1] <= st_y[0];
    st_y[2] <= st_y[1];
    st_c[1] <= st_c[0];
    st_c[2] <= st_c[1];
    if (bus.cell_x_valid & bus.cell_x_ready) n_hs <= n_hs + 1;
    st2_v <= {st2_v[1:0], bus2.cell_x_valid & bus2.cell_x_ready};
    st2_y[0] <= bus2.cell_x_in + bus2.cell_h_in;
    st2_c[0] <= bus2.cell_C_in + 16'sd1;
    st2_y[1] <= st2_y[0];
    st2_y[2] <= st2_y[1];
    st2_c[1] <= st2_c[0];
    st2_c[2] <= st2_c[1];
  end

  assign bus.cell_y_valid  = st_v[2];
  assign bus.cell_y_out    = st_y[2];
  assign bus.cell_C_out    = st_c[2];
  assign bus2.cell_y_valid = st2_v[2];
  assign bus2.cell_y_out   = st2_y[2];
  assign bus2.cell_C_out   = st2_c[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Waits (bounded) for s_ready, presents one sample; returns one cycle after the accept.
  task automatic send(input logic signed [15:0] x, input logic last);
    for (int k = 0; k < 40 && !bus.s_ready; k++) tick();
    chk("s_ready", bus.s_ready, 1);
    bus.s_x     = x;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Cycles from the accept until m_valid is seen (first call point is accept+1).
  task automatic await_out(output int lat);
    lat = 1;
    while (!bus.m_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk("m_valid", bus.m_valid, 1);
  endtask

  task automatic step(input logic signed [15:0] x, input logic last,
                      input int exp_h, input int exp_step, input logic exp_last);
    int lat;
    send(x, last);
    await_out(lat);
    chk("latency", lat, 5);
    chk("m_h", bus.m_h, exp_h);
    chk("m_step", bus.m_step, exp_step);
    chk("m_last", bus.m_last, exp_last);
    tick();
  endtask

  int exp_step2 [6] = '{0, 1, 2, 3, 3, 3};
  int exp_h2    [6] = '{1, 3, 6, 10, 15, 21};

  initial begin
    int lat;
    int hs0;
    logic seen;
    bus.s_x = '0;  bus.s_last = 1'b0;  bus.s_valid = 1'b0;
    bus.cell_x_ready = 1'b1;  bus.m_ready = 1'b1;
    bus2.s_x = '0; bus2.s_last = 1'b0; bus2.s_valid = 1'b0;
    bus2.cell_x_ready = 1'b1; bus2.m_ready = 1'b1;

    repeat (3) tick();
    chk("rst_ctl", {bus.s_ready, bus.cell_x_valid, bus.m_valid, bus.m_last, bus.err_unexpected}, 0);
    chk("rst_data", {bus.m_h, bus.cell_x_in, bus.cell_h_in, bus.cell_C_in}, 0);
    chk("rst_step", bus.m_step, 0);
    rst = 1'b1;
    tick();
    chk("rdy_after_rst", bus.s_ready, 1);

`ifdef LSTM_SEQ_FINAL_ONLY_EN
    seen = 1'b0;
    send(16'sd1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (bus.m_valid) seen = 1'b1;
      tick();
    end
    send(16'sd2, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (bus.m_valid) seen = 1'b1;
      tick();
    end
    chk("fo_quiet", seen, 0);
    send(16'sd3, 1'b1);
    await_out(lat);
    chk("fo_h", bus.m_h, 6);
    chk("fo_step", bus.m_step, 2);
    chk("fo_last", bus.m_last, 1);
    tick();
`else
    // three-step sequence
    step(16'sd10, 1'b0, 10, 0, 1'b0);
    step(16'sd20, 1'b0, 30, 1, 1'b0);
    step(16'sd30, 1'b1, 60, 2, 1'b1);

    // back-to-back sequences: second starts from zero state
    step(16'sd5, 1'b1, 5, 0, 1'b1);
    send(16'sd7, 1'b1);
    chk("seq2_ops", {bus.cell_x_in, bus.cell_h_in, bus.cell_C_in}, {16'sd7, 16'sd0, 16'sd0});
    await_out(lat);
    chk("seq2_h", bus.m_h, 7);
    tick();

    // cell_x_ready stall then m_ready stall
    bus.cell_x_ready = 1'b0;
    hs0 = n_hs;
    send(16'sd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("iss_hold", {bus.cell_x_valid, bus.cell_x_in, bus.cell_h_in, bus.cell_C_in},
          {1'b1, 16'sd4, 16'sd0, 16'sd0});
      tick();
    end
    bus.cell_x_ready = 1'b1;
    bus.m_ready = 1'b0;
    await_out(lat);
    for (int i = 0; i < 6; i++) begin
      chk("out_hold", {bus.m_valid, bus.s_ready, bus.m_h}, {1'b1, 1'b0, 16'sd4});
      if (i < 5) tick();
    end
    bus.m_ready = 1'b1;
    chk("one_cell_hs", n_hs - hs0, 1);
    tick();
    send(16'sd6, 1'b1);
    chk("step2_ops", {bus.cell_x_in, bus.cell_h_in, bus.cell_C_in}, {16'sd6, 16'sd4, 16'sd1});
    await_out(lat);
    chk("step2_h", bus.m_h, 10);
    chk("step2_step", bus.m_step, 1);
    chk("step2_last", bus.m_last, 1);
    tick();

    // reset during WAIT with the result still in the stub pipeline
    send(16'sd9, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {bus.s_ready, bus.cell_x_valid, bus.m_valid, bus.m_last, bus.err_unexpected}, 0);
    chk("mid_rst_data", {bus.m_h, bus.cell_x_in, bus.cell_h_in, bus.cell_C_in}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    tick();
    chk("late_err", bus.err_unexpected, 1);
    chk("late_state", {bus.m_valid, bus.m_h, bus.cell_h_in, bus.m_step}, 0);
    send(16'sd3, 1'b1);
    chk("post_rst_ops", {bus.cell_x_in, bus.cell_h_in, bus.cell_C_in}, {16'sd3, 16'sd0, 16'sd0});
    await_out(lat);
    chk("post_rst_h", bus.m_h, 3);
    chk("post_rst_step", bus.m_step, 0);
    chk("err_sticky", bus.err_unexpected, 1);
    tick();

    // 2-bit step counter saturates at 3
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 40 && !bus2.s_ready; k++) tick();
      chk("sat_s_ready", bus2.s_ready, 1);
      bus2.s_x     = 16'(i + 1);
      bus2.s_last  = (i == 5);
      bus2.s_valid = 1'b1;
      tick();
      bus2.s_valid = 1'b0;
      for (int k = 0; k < 40 && !bus2.m_valid; k++) tick();
      chk("sat_m_valid", bus2.m_valid, 1);
      chk("sat_step", bus2.m_step, exp_step2[i]);
      chk("sat_h", bus2.m_h, exp_h2[i]);
      tick();
    end
    chk("sat_clear", bus2.m_step, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lstm_seq_ctrl.md
# lstm_seq_ctrl

Sequencer that drives the single-step `lstm` cell across a time series. Accepts one input sample per step from an upstream stream, presents it to the cell together with the recurrent hidden state `h` and cell state `C` held in local registers, captures the cell's `y_out`/`C_out` back into those registers, and emits the hidden state downstream. Sits between the sample source and the `lstm` datapath. Weights and biases are static configuration wired straight to the cell; this block does not touch them.

## Interface
Parameters:
- `WIDTH`, 16: sample/state width, signed two's complement; must match the cell.
- `CNT_W`, 16: step-counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (`rst`=0 resets); deassert synchronised externally.
- `s_x`  in  WIDTH  input sample.
- `s_last`  in  1  sample is the final step of its sequence.
- `s_valid` / `s_ready`  in / out  1  upstream handshake.
- `cell_x_in`, `cell_h_in`, `cell_C_in`  out  WIDTH  operands to cell `x_in`, `h_in`, `C_in`.
- `cell_x_valid` / `cell_x_ready`  out / in  1  cell input handshake.
- `cell_y_out`, `cell_C_out`  in  WIDTH  cell results.
- `cell_y_valid`  in  1  one-cycle result strobe; the cell has no backpressure.
- `m_h`  out  WIDTH  hidden state after the step.
- `m_step`  out  CNT_W  zero-based step index within the sequence.
- `m_last`  out  1  step was the sequence's last.
- `m_valid` / `m_ready`  out / in  1  downstream handshake.
- `err_unexpected`  out  1  sticky: `cell_y_valid` seen outside WAIT.

## Operation
- State registers `h_reg`, `C_reg`, `step_cnt`, `x_reg`, `last_reg`.
- FSM:
  - IDLE: `s_ready`=1. On `s_valid`, latch `x_reg`/`last_reg` and go to ISSUE.
  - ISSUE: `cell_x_valid`=1 with `x_reg`/`h_reg`/`C_reg`, held stable until `cell_x_ready`, then go to WAIT.
  - WAIT: on `cell_y_valid`, `h_reg`←`cell_y_out`, `C_reg`←`cell_C_out`, go to OUT.
  - OUT: `m_valid`=1, `m_h`=`h_reg`, `m_step`=`step_cnt`, `m_last`=`last_reg`, held until `m_ready`. On the handshake:
    - if `last_reg`: `h_reg`, `C_reg` and `step_cnt` are cleared to 0;
    - otherwise `step_cnt` increments, saturating at 2^CNT_W−1.
    - Then go to IDLE.
- One step is in flight at a time; `s_ready` is low outside IDLE.
- The first step after reset, and the first after any `last`, uses `h`=0 and `C`=0.
- State values are stored raw with no arithmetic; width is exactly WIDTH.
- `cell_y_valid` in IDLE/ISSUE/OUT is ignored for state and sets `err_unexpected`, which is cleared only by reset.
- Reset mid-operation: every register returns to its reset value and the FSM to IDLE. A result returning late from the cell sets `err_unexpected` and does not corrupt state.

## Timing
- Reset values: `s_ready`=0 while `rst`=0, and 1 in IDLE from the first cycle after release. `cell_x_valid`=0, `m_valid`=0, `m_last`=0, `err_unexpected`=0, all data outputs 0.
- Accept in cycle T. `cell_x_valid` rises in T+1. With `cell_x_ready` high, the cell result arrives at T+1+L. `m_valid` rises at T+2+L.
- With `m_ready` held high, IDLE is re-entered at T+3+L. Throughput is one step per L+3 cycles.
- All outputs are registered; no combinational path from input to output, except that `cell_x_valid` does not depend on `cell_x_ready`.

## Configuration
- `LSTM_SEQ_FINAL_ONLY_EN` defined: OUT is entered only when `last_reg`=1. Non-last steps go WAIT→IDLE directly, with `step_cnt` incremented, and emit nothing downstream.
- Undefined: every step is emitted, as described above.

## Structure
- Package `lstm_pkg`: `WIDTH` default, `typedef logic signed [WIDTH-1:0] lstm_word_t`, FSM enum `lstm_seq_state_e` {IDLE, ISSUE, WAIT, OUT}.
- No sub-module; a single FSM plus registers.
- The bench instantiates `lstm_seq_ctrl` with a stub cell model: fixed latency L=3, `y`=`x`+`h`, `C_out`=`C`+1.

## Test plan
- Single sequence of 3 samples (10, 20, 30), last on 30, `m_ready`=1: `m_h` = 10, 30, 60; `m_step` = 0, 1, 2; `m_last` only on the third; `m_valid` 5 cycles after each accept.
- Two back-to-back sequences (5 last, then 7 last): the second step sees `h_in`=0 and `C_in`=0, and `m_h`=7.
- `cell_x_ready` held low 4 cycles in ISSUE: operands stay stable throughout, with exactly one cell handshake. `m_ready` held low 6 cycles: `m_valid` and `m_h` held and `s_ready` stays 0.
- `rst` asserted during WAIT, then stub result returns: all outputs at reset values, `err_unexpected`=1, next sequence starts from `h`=0.
- `CNT_W`=2 with a 6-step sequence: `m_step` = 0, 1, 2, 3, 3, 3.
- With `LSTM_SEQ_FINAL_ONLY_EN` and samples (1, 2, 3 last): a single output, `m_h`=6, `m_step`=2, `m_last`=1.
